// File: rtl/alarm_timer_pkg.sv
//------------------------------------------------------------------------------
// Module : alarm_timer_pkg
// Brief  : Shared timer-s1 register map, control/status bits, FSM states, limits
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package alarm_timer_pkg;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIODL = 3'd2;
  localparam logic [2:0] ADDR_PERIODH = 3'd3;
  localparam logic [2:0] ADDR_SNAPL   = 3'd4;
  localparam logic [2:0] ADDR_SNAPH   = 3'd5;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOPB = 3;

  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;

  localparam logic [4:0] HOUR_MAX = 5'd23;
  localparam logic [5:0] MS_MAX   = 6'd59;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_CTRL  = 3'd1,
    ST_WAIT_IRQ = 3'd2,
    ST_WR_CLR   = 3'd3,
    ST_RD_ADDR  = 3'd4,
    ST_RD_CAP   = 3'd5,
    ST_WR_STOP  = 3'd6
  } state_t;

  function automatic logic [4:0] clamp_h(input logic [4:0] v);
    return (v > HOUR_MAX) ? HOUR_MAX : v;
  endfunction

  function automatic logic [5:0] clamp_ms(input logic [5:0] v);
    return (v > MS_MAX) ? MS_MAX : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alarm_hms_counter.sv
//------------------------------------------------------------------------------
// Module : alarm_hms_counter
// Brief  : Cascaded mod-60/60/24 time-of-day counter with clamped load
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alarm_hms_counter
  import alarm_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       i_load,
  input  logic [4:0] i_set_h,
  input  logic [5:0] i_set_m,
  input  logic [5:0] i_set_s,
  output logic [4:0] o_hours,
  output logic [5:0] o_minutes,
  output logic [5:0] o_seconds
);

  logic [4:0] r_h;
  logic [5:0] r_m;
  logic [5:0] r_s;

  // A load in the same cycle as a tick wins; the tick's advance is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h <= '0;
      r_m <= '0;
      r_s <= '0;
    end else if (i_load) begin
      r_h <= clamp_h(i_set_h);
      r_m <= clamp_ms(i_set_m);
      r_s <= clamp_ms(i_set_s);
    end else if (i_tick) begin
      if (r_s == MS_MAX) begin
        r_s <= '0;
        if (r_m == MS_MAX) begin
          r_m <= '0;
          r_h <= (r_h == HOUR_MAX) ? 5'd0 : r_h + 5'd1;
        end else begin
          r_m <= r_m + 6'd1;
        end
      end else begin
        r_s <= r_s + 6'd1;
      end
    end
  end

  assign o_hours   = r_h;
  assign o_minutes = r_m;
  assign o_seconds = r_s;

endmodule

`default_nettype wire

// File: rtl/alarm_timer_master.sv
//------------------------------------------------------------------------------
// Module : alarm_timer_master
// Brief  : Avalon-MM master servicing interval-timer IRQs and keeping hh:mm:ss
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alarm_timer_master
  import alarm_timer_pkg::*;
#(
  parameter logic [15:0] CTRL_RUN  = 16'((1 << CTRL_START) | (1 << CTRL_CONT) | (1 << CTRL_ITO)),
  parameter logic [15:0] CTRL_STOP = 16'(1 << CTRL_STOPB),
  parameter int          MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [2:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [15:0] avm_writedata,
  input  logic [15:0] avm_readdata,
  input  logic        timer_irq,
  input  logic        set_valid,
  input  logic [4:0]  set_h,
  input  logic [5:0]  set_m,
  input  logic [5:0]  set_s,
  output logic [4:0]  hours,
  output logic [5:0]  minutes,
  output logic [5:0]  seconds,
  output logic        sec_tick,
  output logic        fault
);

  localparam int RW = $clog2(MAX_RETRY + 1);

  state_t          r_state;
  logic [2:0]      r_addr;
  logic            r_cs;
  logic            r_wr_n;
  logic [15:0]     r_wdata;
  logic            r_tick;
  logic            r_fault;
  logic [RW-1:0]   r_retry;
  logic            w_rd_unused;

  assign w_rd_unused = ^{avm_readdata[15:2], avm_readdata[STAT_TO]};

  // Bus outputs are registered on the edge that enters each state, so the
  // strobe pattern is visible for exactly the cycle the FSM sits in it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_cs    <= 1'b0;
      r_wr_n  <= 1'b1;
      r_wdata <= '0;
      r_tick  <= 1'b0;
      r_fault <= 1'b0;
      r_retry <= '0;
    end else begin
      r_tick <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cs   <= 1'b0;
          r_wr_n <= 1'b1;
          if (enable) begin
            r_state <= ST_WR_CTRL;
            r_cs    <= 1'b1;
            r_wr_n  <= 1'b0;
            r_addr  <= ADDR_CONTROL;
            r_wdata <= CTRL_RUN;
          end
        end
        ST_WR_CTRL: begin
          r_state <= ST_WAIT_IRQ;
          r_cs    <= 1'b0;
          r_wr_n  <= 1'b1;
          r_addr  <= '0;
          r_wdata <= '0;
        end
        ST_WAIT_IRQ: begin
          if (!enable) begin
            r_state <= ST_WR_STOP;
            r_cs    <= 1'b1;
            r_wr_n  <= 1'b0;
            r_addr  <= ADDR_CONTROL;
            r_wdata <= CTRL_STOP;
          end else if (timer_irq) begin
            r_state <= ST_WR_CLR;
            r_cs    <= 1'b1;
            r_wr_n  <= 1'b0;
            r_addr  <= ADDR_STATUS;
            r_wdata <= 16'h0000;
            r_tick  <= 1'b1;
          end
        end
        ST_WR_CLR: begin
          r_state <= ST_RD_ADDR;
          r_cs    <= 1'b1;
          r_wr_n  <= 1'b1;
          r_addr  <= ADDR_STATUS;
        end
        ST_RD_ADDR: begin
          r_state <= ST_RD_CAP;
        end
        ST_RD_CAP: begin
          if (avm_readdata[STAT_RUN]) begin
            r_state <= ST_WAIT_IRQ;
            r_cs    <= 1'b0;
            r_wr_n  <= 1'b1;
            r_addr  <= '0;
            r_retry <= '0;
          end else begin
            r_state <= ST_WR_CTRL;
            r_cs    <= 1'b1;
            r_wr_n  <= 1'b0;
            r_addr  <= ADDR_CONTROL;
            r_wdata <= CTRL_RUN;
            if (r_retry != RW'(MAX_RETRY))
              r_retry <= r_retry + 1'b1;
            if (r_retry >= RW'(MAX_RETRY - 1))
              r_fault <= 1'b1;
          end
        end
        ST_WR_STOP: begin
          r_state <= ST_IDLE;
          r_cs    <= 1'b0;
          r_wr_n  <= 1'b1;
          r_addr  <= '0;
          r_wdata <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  alarm_hms_counter u_hms (
    .clk       (clk),
    .rst       (reset),
    .i_tick    (r_state == ST_WR_CLR),
    .i_load    (set_valid),
    .i_set_h   (set_h),
    .i_set_m   (set_m),
    .i_set_s   (set_s),
    .o_hours   (hours),
    .o_minutes (minutes),
    .o_seconds (seconds)
  );

  assign avm_address    = r_addr;
  assign avm_chipselect = r_cs;
  assign avm_write_n    = r_wr_n;
  assign avm_writedata  = r_wdata;
  assign sec_tick       = r_tick;
  assign fault          = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_alarm_timer_master.sv
//------------------------------------------------------------------------------
// Module : tb_alarm_timer_master
// Brief  : Directed self-checking bench for alarm_timer_master
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_alarm_timer_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata = 16'h0000;
  logic        timer_irq = 1'b0;
  logic        set_valid = 1'b0;
  logic [4:0]  set_h = '0;
  logic [5:0]  set_m = '0;
  logic [5:0]  set_s = '0;
  logic [4:0]  hours;
  logic [5:0]  minutes;
  logic [5:0]  seconds;
  logic        sec_tick;
  logic        fault;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alarm_timer_master dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .timer_irq      (timer_irq),
    .set_valid      (set_valid),
    .set_h          (set_h),
    .set_m          (set_m),
    .set_s          (set_s),
    .hours          (hours),
    .minutes        (minutes),
    .seconds        (seconds),
    .sec_tick       (sec_tick),
    .fault          (fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {cs, write_n, address, writedata}
  function automatic logic [20:0] bus();
    return {avm_chipselect, avm_write_n, avm_address, avm_writedata};
  endfunction

  function automatic logic [16:0] hms();
    return {hours, minutes, seconds};
  endfunction

  localparam logic [20:0] BUS_IDLE  = {1'b0, 1'b1, 3'd0, 16'h0000};
  localparam logic [20:0] BUS_RUN   = {1'b1, 1'b0, 3'd1, 16'h0007};
  localparam logic [20:0] BUS_STOP  = {1'b1, 1'b0, 3'd1, 16'h0008};
  localparam logic [20:0] BUS_CLR   = {1'b1, 1'b0, 3'd0, 16'h0000};

  // One IRQ service from WAIT_IRQ: WR_CLR, RD_ADDR, RD_CAP, then the next state.
  task automatic service(input string tag, input logic [15:0] status,
                         input logic [16:0] exp_hms, input logic exp_fault);
    avm_readdata = status;
    timer_irq = 1'b1;
    step();
    chk({tag, "_clr_bus"}, bus(), BUS_CLR);
    chk({tag, "_tick"}, sec_tick, 1'b1);
    step();
    timer_irq = 1'b0;
    chk({tag, "_rdaddr"}, {avm_chipselect, avm_write_n, avm_address}, {1'b1, 1'b1, 3'd0});
    chk({tag, "_hms"}, hms(), exp_hms);
    step();
    chk({tag, "_rdcap"}, {avm_chipselect, avm_write_n, avm_address}, {1'b1, 1'b1, 3'd0});
    step();
    chk({tag, "_after_bus"}, bus(), status[1] ? BUS_IDLE : BUS_RUN);
    chk({tag, "_fault"}, fault, exp_fault);
    if (!status[1]) step();
  endtask

  initial begin
    repeat (3) step();
    chk("rst_bus", bus(), BUS_IDLE);
    chk("rst_hms", hms(), 17'd0);
    chk("rst_tick_fault", {sec_tick, fault}, 2'b00);
    reset = 1'b0;
    step();
    chk("idle_no_enable", bus(), BUS_IDLE);
    enable = 1'b1;
    step();
    chk("start_wr_ctrl", bus(), BUS_RUN);
    step();
    chk("wait_bus_idle", bus(), BUS_IDLE);
    repeat (3) step();
    chk("wait_still_idle", bus(), BUS_IDLE);

    service("irq1", 16'h0002, {5'd0, 6'd0, 6'd1}, 1'b0);

    // Out-of-range preset clamps to 23:59:59
    set_h = 5'd31; set_m = 6'd63; set_s = 6'd63; set_valid = 1'b1;
    step();
    set_valid = 1'b0;
    chk("clamp_hms", hms(), {5'd23, 6'd59, 6'd59});
    service("wrap", 16'h0002, 17'd0, 1'b0);

    // Load coincident with WR_CLR wins over the advance
    avm_readdata = 16'h0002;
    timer_irq = 1'b1;
    step();
    chk("ld_clr_tick", sec_tick, 1'b1);
    set_h = 5'd10; set_m = 6'd20; set_s = 6'd30; set_valid = 1'b1;
    step();
    set_valid = 1'b0;
    timer_irq = 1'b0;
    chk("ld_clr_hms", hms(), {5'd10, 6'd20, 6'd30});
    step();
    step();
    chk("ld_clr_done", bus(), BUS_IDLE);

    service("retry1", 16'h0000, {5'd10, 6'd20, 6'd31}, 1'b0);
    service("retry2", 16'h0000, {5'd10, 6'd20, 6'd32}, 1'b0);
    service("retry3", 16'h0000, {5'd10, 6'd20, 6'd33}, 1'b1);
    service("run_ok", 16'h0002, {5'd10, 6'd20, 6'd34}, 1'b1);

    // Enable dropped during RD_ADDR: read finishes, then STOP write
    avm_readdata = 16'h0002;
    timer_irq = 1'b1;
    step();
    step();
    timer_irq = 1'b0;
    enable = 1'b0;
    chk("dis_rdaddr", {avm_chipselect, avm_write_n}, 2'b11);
    step();
    chk("dis_rdcap", {avm_chipselect, avm_write_n}, 2'b11);
    step();
    chk("dis_wait", bus(), BUS_IDLE);
    step();
    chk("dis_wr_stop", bus(), BUS_STOP);
    step();
    chk("dis_idle", bus(), BUS_IDLE);
    timer_irq = 1'b1;
    repeat (4) step();
    chk("dis_irq_ignored", {bus(), sec_tick}, {BUS_IDLE, 1'b0});
    chk("dis_hms_kept", hms(), {5'd10, 6'd20, 6'd35});
    timer_irq = 1'b0;

    enable = 1'b1;
    step();
    chk("reen_wr_ctrl", bus(), BUS_RUN);
    chk("reen_hms_fault", {hms(), fault}, {5'd10, 6'd20, 6'd35, 1'b1});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
